sigmoid_backprop_delta: RTL and testbench

SIGMOID_BACKPROP_DELTA -- requirements
Module: sigmoid_backprop_delta

---
 rtl/sigmoid_backprop_delta.sv | 174 +++++++++++++++++
 tb/tb_sigmoid_backprop_delta.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_backprop_delta.sv
// Sigmoid back-propagation delta: delta = err * y * (1 - y), fixed point.
// Optional macro DELTA_SAT_EN: saturate error subtraction and final product.
module sigmoid_backprop_delta #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] sig_in,
  input  logic [DATA_W-1:0] err_in,
  input  logic              is_output,
  input  logic [31:0]       n_idx_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] delta_out,
  output logic [31:0]       n_idx_out
);

  localparam int PW = 2 * DATA_W;
  localparam int HW = PW - FRAC_W - DATA_W + 1;

  localparam logic [DATA_W-1:0] ONE =
    {{(DATA_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
  localparam logic [DATA_W-1:0] S_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] S_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    MUL1,
    MUL2,
    DONE
  } state_t;

  state_t state;

  logic [DATA_W-1:0] sig_q;
  logic [DATA_W-1:0] err_q;
  logic              is_out_q;
  logic [31:0]       tag_q;

  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] om_q;
  logic [DATA_W-1:0] e_q;
  logic [DATA_W-1:0] p1_q;

  logic [DATA_W-1:0] y_clamp;
  logic [DATA_W-1:0] om_c;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] err_sub;
  logic [DATA_W-1:0] e_c;

  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic [HW-1:0]     prod_hi;
  logic [DATA_W-1:0] mul_res;
  logic              unused_bits;

  assign in_ready = (state == IDLE) && !rst;

  // Clamp the activation into [0, 1.0]
  always_comb begin
    y_clamp = sig_q;
    if (sig_q[DATA_W-1]) begin
      y_clamp = '0;
    end else if (sig_q > ONE) begin
      y_clamp = ONE;
    end
  end

  assign om_c = ONE - y_clamp;

  assign diff = {err_q[DATA_W-1], err_q}
              - {y_clamp[DATA_W-1], y_clamp};

  // Output-layer error: target minus activation, reduced to DATA_W
  always_comb begin
`ifdef DELTA_SAT_EN
    err_sub = diff[DATA_W-1:0];
    if (diff[DATA_W] != diff[DATA_W-1]) begin
      err_sub = diff[DATA_W] ? S_MIN : S_MAX;
    end
`else
    err_sub = diff[DATA_W-1:0];
`endif
  end

  assign e_c = is_out_q ? err_sub : err_q;

  // Shared multiplier operand select: y*om in MUL1, p1*err in MUL2
  always_comb begin
    mul_a = y_q;
    mul_b = om_q;
    if (state == MUL2) begin
      mul_a = p1_q;
      mul_b = e_q;
    end
  end

  assign a_ext = {{DATA_W{mul_a[DATA_W-1]}}, mul_a};
  assign b_ext = {{DATA_W{mul_b[DATA_W-1]}}, mul_b};
  assign prod  = a_ext * b_ext;
  assign prod_hi = prod[PW-1:FRAC_W+DATA_W-1];

  // Scale the product back by FRAC_W and reduce to DATA_W
  always_comb begin
`ifdef DELTA_SAT_EN
    mul_res = prod[FRAC_W +: DATA_W];
    if (!((&prod_hi) || !(|prod_hi))) begin
      mul_res = prod[PW-1] ? S_MIN : S_MAX;
    end
    unused_bits = ^prod[FRAC_W-1:0];
`else
    mul_res = prod[FRAC_W +: DATA_W];
    unused_bits = ^{prod[FRAC_W-1:0], prod_hi, diff[DATA_W]};
`endif
  end

  // Control FSM with registered datapath and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      delta_out <= '0;
      n_idx_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sig_q    <= sig_in;
            err_q    <= err_in;
            is_out_q <= is_output;
            tag_q    <= n_idx_in;
            state    <= PREP;
          end
        end
        PREP: begin
          y_q   <= y_clamp;
          om_q  <= om_c;
          e_q   <= e_c;
          state <= MUL1;
        end
        MUL1: begin
          p1_q  <= mul_res;
          state <= MUL2;
        end
        MUL2: begin
          delta_out <= mul_res;
          n_idx_out <= tag_q;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_backprop_delta.sv
// Bench for sigmoid_backprop_delta: directed vectors,
// reference model and per-cycle output monitor.
module tb_sigmoid_backprop_delta;

  localparam longint ONE_L = 64'sd16777216;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] sig_in = '0;
  logic [31:0] err_in = '0;
  logic        is_output = 1'b0;
  logic [31:0] n_idx_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] delta_out;
  logic [31:0] n_idx_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] d;
    logic [31:0] t;
  } exp_t;

  exp_t q[$];
  bit   busy = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   hs_cyc = 0;

  sigmoid_backprop_delta #(
    .DATA_W(32),
    .FRAC_W(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sig_in(sig_in),
    .err_in(err_in),
    .is_output(is_output),
    .n_idx_in(n_idx_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .delta_out(delta_out),
    .n_idx_out(n_idx_out)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a,
                              logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endfunction

  function automatic longint fit(longint x);
`ifdef DELTA_SAT_EN
    if (x > 64'sd2147483647) return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
`else
    logic [31:0] lo;
    lo = x[31:0];
    return longint'($signed(lo));
`endif
  endfunction

  function automatic logic [31:0] model(logic [31:0] s,
                                        logic [31:0] e,
                                        logic iso);
    longint y, om, er, p1, d;
    y = longint'($signed(s));
    if (y < 0) y = 0;
    if (y > ONE_L) y = ONE_L;
    om = ONE_L - y;
    er = longint'($signed(e));
    if (iso) er = fit(er - y);
    p1 = (y * om) >>> 24;
    d = fit((p1 * er) >>> 24);
    return d[31:0];
  endfunction

  always @(negedge clk) begin
    bit exp_rdy;
    bit exp_ov;
    cyc++;
    exp_rdy = !rst && !busy;
    exp_ov = busy && ((cyc - acc_cyc) >= 4);
    chk("mon_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("mon_out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected: got %h want none",
                 delta_out);
      end else begin
        chk("mon_delta", delta_out, q[0].d);
        chk("mon_tag", n_idx_out, q[0].t);
      end
    end
    if (rst) begin
      busy = 0;
      q.delete();
    end else begin
      if (out_valid && out_ready && busy) begin
        busy = 0;
        void'(q.pop_front());
        hs_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        exp_t x;
        x.d = model(sig_in, err_in, is_output);
        x.t = n_idx_in;
        q.push_back(x);
        busy = 1;
        acc_cyc = cyc;
      end
    end
  end

  task automatic send(input logic [31:0] s, input logic [31:0] e,
                      input logic iso, input logic [31:0] tag);
    int n;
    sig_in = s;
    err_in = e;
    is_output = iso;
    n_idx_in = tag;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got busy want ready");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic get(input string nm, input logic [31:0] exp,
                     input logic [31:0] tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got idle want valid", nm);
    end else begin
      chk(nm, delta_out, exp);
      chk({nm, "_tag"}, n_idx_out, tag);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] s, e, ovf_exp;
    logic iso;

`ifdef DELTA_SAT_EN
    ovf_exp = 32'hE000_0000;
`else
    ovf_exp = 32'h1FE0_0000;
`endif

    chk("model_hidden", model(32'h0080_0000, 32'h0100_0000, 1'b0),
        32'h0040_0000);
    chk("model_outl", model(32'h0080_0000, 32'h0100_0000, 1'b1),
        32'h0020_0000);
    chk("model_ovf", model(32'h0080_0000, 32'h8000_0000, 1'b1),
        ovf_exp);
    chk("model_floor", model(32'h0080_0000, 32'hFFFF_FFFF, 1'b0),
        32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_delta", delta_out, 32'd0);
    chk("rst_tag", n_idx_out, 32'd0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ignored_valid", {31'd0, out_valid}, 32'd0);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    send(32'h0080_0000, 32'h0100_0000, 1'b0, 32'd7);
    get("hidden", 32'h0040_0000, 32'd7);
    send(32'h0080_0000, 32'h0100_0000, 1'b1, 32'd8);
    get("outlayer", 32'h0020_0000, 32'd8);
    send(32'h0133_3333, 32'h0100_0000, 1'b0, 32'd9);
    get("clamp_hi", 32'h0000_0000, 32'd9);
    send(32'hFF00_0000, 32'h0100_0000, 1'b0, 32'd10);
    get("clamp_neg", 32'h0000_0000, 32'd10);
    send(32'h0080_0000, 32'h8000_0000, 1'b1, 32'd11);
    get("overflow", ovf_exp, 32'd11);
    send(32'h0040_0000, 32'hFF00_0000, 1'b0, 32'd12);
    get("neg_err", 32'hFFD0_0000, 32'd12);
    send(32'h00C0_0000, 32'h0000_0000, 1'b1, 32'd13);
    get("outl_neg", 32'hFFDC_0000, 32'd13);
    send(32'h0080_0000, 32'hFFFF_FFFF, 1'b0, 32'd14);
    get("floor_shift", 32'hFFFF_FFFF, 32'd14);
    send(32'h0100_0000, 32'h0100_0000, 1'b0, 32'd15);
    get("y_one", 32'h0000_0000, 32'd15);

    out_ready = 1'b0;
    send(32'h0080_0000, 32'h0100_0000, 1'b0, 32'd20);
    get("bp_first", 32'h0040_0000, 32'd20);
    sig_in = 32'h0080_0000;
    err_in = 32'h0100_0000;
    is_output = 1'b1;
    n_idx_in = 32'd21;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_delta", delta_out, 32'h0040_0000);
      chk("bp_hold_tag", n_idx_out, 32'd20);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(32'h0080_0000, 32'h0100_0000, 1'b1, 32'd21);
    chk("bp_accept_next", acc_cyc - hs_cyc, 32'd1);
    get("bp_second", 32'h0020_0000, 32'd21);

    send(32'h0080_0000, 32'h0100_0000, 1'b0, 32'd30);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    send(32'h0040_0000, 32'hFF00_0000, 1'b0, 32'd31);
    get("after_rst", 32'hFFD0_0000, 32'd31);

    for (int i = 0; i < 6; i++) begin
      s = $urandom_range(0, 32'h0110_0000);
      e = $urandom;
      iso = 1'($urandom_range(0, 1));
      send(s, e, iso, 32'd40 + i);
      get("rand", model(s, e, iso), 32'd40 + i);
    end

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
